// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO read-side controller.
package fifo_pkg;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order valid/ready buffer; head entry is always the output word.
module skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  assign pop = pop_i && (cnt_q != 2'd0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_i, pop})
      2'b10: begin
        // Upstream slot accounting makes a push into a full buffer impossible.
        if (cnt_q != 2'd2) begin
          if (cnt_q == 2'd0) head_d = din_i;
          else               tail_d = din_i;
          cnt_d = cnt_q + 2'd1;
        end
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign dout_o  = head_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side controller: issues FIFO reads, hides the one-cycle read latency,
// and emits a framed valid/ready stream through a 2-entry buffer.
module sync_fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_r_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);
  localparam logic [15:0] WIDX_MAX = 16'(FRAME_LEN - 1);

  state_e                 state_q, state_d;
  logic                   inflight_q;
  logic [15:0]            widx_q, widx_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic [1:0]             buf_cnt;
  logic                   pop;
  logic [2:0]             occ;

  skid_buf2 #(.W(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .din_i   (fifo_data),
    .pop_i   (pop),
    .valid_o (m_valid),
    .dout_o  (m_data),
    .count_o (buf_cnt)
  );

  assign pop = m_valid && m_ready;

  // Slots already promised: buffered plus in-flight, less the word leaving now.
  assign occ       = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_r_en = (state_q == RUN) && !fifo_empty && (occ < 3'd2);

  assign m_last    = m_valid && (widx_q == WIDX_MAX);
  assign busy      = (state_q != IDLE);
  assign frame_cnt = fcnt_q;

  always_comb begin
    widx_d = widx_q;
    fcnt_d = fcnt_q;
    if (pop) begin
      if (m_last) begin
        widx_d = 16'd0;
        fcnt_d = fcnt_q + 1'b1;
      end else begin
        widx_d = widx_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                                 state_d = RUN;
        else if (!inflight_q && (buf_cnt == 2'd0))  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      widx_q     <= 16'd0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_r_en;
      widx_q     <= widx_d;
      fcnt_q     <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_sync_fifo_reader.sv
// Scoreboard bench: two readers (FRAME_LEN 4 and 1) each fed by a DEPTH=8 FIFO model.
module tb_sync_fifo_reader;
  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic m_ready = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        fe, ren, mv, ml, bz, frd, fwe;
  logic [1:0][7:0]   md;
  logic [1:0][7:0]   fd = '0;
  logic [1:0][15:0]  fc;
  logic [1:0]        fwr = 2'b00;
  logic [1:0][7:0]   fwd = '0;
  logic [7:0]        fmem [2][8];
  int                fwp [2] = '{0, 0};
  int                frp [2] = '{0, 0};
  int                fcnt[2] = '{0, 0};

  exp_t q0[$], q1[$];
  int   wi[2] = '{0, 0};
  int   nchk = 0, nbad = 0;

  sync_fifo_reader #(.DATA_WIDTH(8), .FRAME_LEN(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fe[0]), .fifo_data(fd[0]),
    .fifo_r_en(ren[0]), .m_valid(mv[0]), .m_ready(m_ready), .m_data(md[0]),
    .m_last(ml[0]), .busy(bz[0]), .frame_cnt(fc[0]));

  sync_fifo_reader #(.DATA_WIDTH(8), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fe[1]), .fifo_data(fd[1]),
    .fifo_r_en(ren[1]), .m_valid(mv[1]), .m_ready(m_ready), .m_data(md[1]),
    .m_last(ml[1]), .busy(bz[1]), .frame_cnt(fc[1]));

  // FIFO model: registered data_out that holds when not read.
  assign fe[0]  = (fcnt[0] == 0);
  assign fe[1]  = (fcnt[1] == 0);
  assign frd[0] = ren[0] && (fcnt[0] != 0);
  assign frd[1] = ren[1] && (fcnt[1] != 0);
  assign fwe[0] = fwr[0] && (fcnt[0] < 8);
  assign fwe[1] = fwr[1] && (fcnt[1] < 8);

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (frd[k]) begin
        fd[k]  <= fmem[k][frp[k]];
        frp[k] <= (frp[k] + 1) % 8;
      end
      if (fwe[k]) begin
        fmem[k][fwp[k]] <= fwd[k];
        fwp[k]          <= (fwp[k] + 1) % 8;
      end
      fcnt[k] <= fcnt[k] + (fwe[k] ? 1 : 0) - (frd[k] ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_pop(input int k);
    exp_t e;
    if (k == 0) begin
      if (q0.size() == 0) begin chk("unexp0", 1, 0); return; end
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) begin chk("unexp1", 1, 0); return; end
      e = q1.pop_front();
    end
    chk(k == 0 ? "data0" : "data1", {24'd0, md[k]}, {24'd0, e.d});
    chk(k == 0 ? "last0" : "last1", {31'd0, ml[k]}, {31'd0, e.l});
  endtask

  // Monitor: sampled on the falling edge, between active edges.
  int   cyc = 0, rden0 = 0, pops0 = 0, pops1 = 0, b2b0 = 0;
  int   prev_pop0 = -10, fall_cyc = -100, vrise_cyc = -1;
  logic pfe0 = 1'b1, pmv0 = 1'b0, hold0 = 1'b0, hl0 = 1'b0;
  logic [7:0] hd0 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ren[0]) rden0 <= rden0 + 1;
      if (ren[0] && fe[0]) chk("ren_empty", 1, 0);
      if (pfe0 && !fe[0]) fall_cyc <= cyc;
      if (!pmv0 && mv[0]) vrise_cyc <= cyc;
      pfe0 <= fe[0];
      pmv0 <= mv[0];
      if (hold0) begin
        chk("hold_data", {24'd0, md[0]}, {24'd0, hd0});
        chk("hold_last", {31'd0, ml[0]}, {31'd0, hl0});
      end
      hold0 <= mv[0] && !m_ready;
      hd0   <= md[0];
      hl0   <= ml[0];
      if (mv[0] && m_ready) begin
        pops0 <= pops0 + 1;
        if (cyc == prev_pop0 + 1) b2b0 <= b2b0 + 1;
        prev_pop0 <= cyc;
        check_pop(0);
      end
      if (mv[1] && m_ready) begin
        pops1 <= pops1 + 1;
        check_pop(1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int k, input logic [7:0] d);
    int   n = 0;
    exp_t e;
    while (fcnt[k] >= 8) begin
      tick();
      n++;
      if (n > 200) begin chk("full_timeout", 0, 1); return; end
    end
    e.d = d;
    e.l = (k == 0) ? ((wi[k] % 4) == 3) : 1'b1;
    wi[k]++;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    fwr[k] = 1'b1;
    fwd[k] = d;
    tick();
    fwr[k] = 1'b0;
  endtask

  task automatic wait_drained(input int k, input int lim);
    int n = 0;
    while (((k == 0) ? q0.size() : q1.size()) != 0 || mv[k]) begin
      tick();
      n++;
      if (n > lim) begin chk("drain_timeout", 0, 1); return; end
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (bz[0]) begin
      tick();
      n++;
      if (n > lim) begin chk("idle_timeout", 0, 1); return; end
    end
  endtask

  int   b, r, del, n;
  logic wdone;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_valid", {31'd0, mv[0]}, 0);
    chk("rst_last",  {31'd0, ml[0]}, 0);
    chk("rst_busy",  {31'd0, bz[0]}, 0);
    chk("rst_fcnt",  {16'd0, fc[0]}, 0);
    chk("rst_data",  {24'd0, md[0]}, 0);
    chk("rst_ren",   {31'd0, ren[0]}, 0);
    rst = 1'b0;
    tick();

    // Basic stream
    enable = 1'b1; m_ready = 1'b1;
    tick(); tick();
    chk("busy_run", {31'd0, bz[0]}, 1);
    b = pops0; r = b2b0;
    push_word(0, 8'h11); push_word(0, 8'h22); push_word(0, 8'h33); push_word(0, 8'h44);
    wait_drained(0, 50);
    tick();
    chk("latency", vrise_cyc - fall_cyc, 2);
    chk("basic_b2b", b2b0 - r, 3);
    chk("basic_pops", pops0 - b, 4);
    chk("basic_fcnt", {16'd0, fc[0]}, 1);

    // Backpressure
    m_ready = 1'b0;
    tick();
    r = rden0; b = pops0;
    for (int i = 0; i < 8; i++) push_word(0, 8'hA0 + 8'(i));
    repeat (10) tick();
    chk("bp_reads", rden0 - r, 2);
    chk("bp_valid", {31'd0, mv[0]}, 1);
    chk("bp_head", {24'd0, md[0]}, 32'hA0);
    m_ready = 1'b1;
    wait_drained(0, 100);
    chk("bp_pops", pops0 - b, 8);
    chk("bp_fcnt", {16'd0, fc[0]}, 3);

    // Random ready
    b = pops0; wdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) push_word(0, 8'($urandom));
        wdone = 1'b1;
      end
      begin
        for (int i = 0; i < 3000 && !(wdone && q0.size() == 0); i++) begin
          tick();
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    wait_drained(0, 100);
    chk("rnd_pops", pops0 - b, 64);
    chk("rnd_fcnt", {16'd0, fc[0]}, 19);

    // Drain: drop enable after 3 deliveries, then resume
    enable = 1'b0;
    wait_idle(50);
    for (int i = 0; i < 8; i++) push_word(0, 8'h50 + 8'(i));
    b = pops0;
    enable = 1'b1;
    n = 0;
    while (pops0 < b + 3 && n < 100) begin tick(); n++; end
    chk("drain_start", {31'd0, (pops0 >= b + 3)}, 1);
    enable = 1'b0;
    tick();
    r = rden0;
    wait_idle(50);
    del = pops0 - b;
    chk("drain_noread", rden0 - r, 0);
    chk("drain_idle", {31'd0, bz[0]}, 0);
    chk("drain_mvalid", {31'd0, mv[0]}, 0);
    chk("drain_left", fcnt[0], 8 - del);
    chk("drain_q", q0.size(), 8 - del);
    enable = 1'b1;
    wait_drained(0, 100);
    chk("resume_pops", pops0 - b, 8);
    chk("resume_fcnt", {16'd0, fc[0]}, 21);

    // FRAME_LEN = 1
    b = pops1;
    for (int i = 0; i < 5; i++) push_word(1, 8'h70 + 8'(i));
    wait_drained(1, 100);
    chk("f1_pops", pops1 - b, 5);
    chk("f1_fcnt", {16'd0, fc[1]}, 5);

    // Mid-frame asynchronous reset
    m_ready = 1'b0;
    push_word(0, 8'hE0); push_word(0, 8'hE1);
    repeat (4) tick();
    chk("pre_valid", {31'd0, mv[0]}, 1);
    chk("pre_fcnt", {16'd0, fc[0]}, 21);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, mv[0]}, 0);
    chk("arst_last",  {31'd0, ml[0]}, 0);
    chk("arst_busy",  {31'd0, bz[0]}, 0);
    chk("arst_fcnt",  {16'd0, fc[0]}, 0);
    chk("arst_ren",   {31'd0, ren[0]}, 0);
    chk("arst_fcnt1", {16'd0, fc[1]}, 0);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
